cmn_stream_mux: RTL

CMN_STREAM_MUX -- requirements
Module: cmn_stream_mux

---
 rtl/cmn_pkg.sv | 5 +
 rtl/cmn_rr_arbiter.sv | 16 +
 rtl/cmn_stream_mux.sv | 80 ++++++++
 3 files changed

// File: rtl/cmn_pkg.sv
// cmn_pkg: shared encodings for the cmn stream blocks
package cmn_pkg;
  localparam int CMN_MUX_MODE_RR  = 0;
  localparam int CMN_MUX_MODE_SEL = 1;
endpackage

// File: rtl/cmn_rr_arbiter.sv
// cmn_rr_arbiter: one-hot grant to the first request at or above ptr, wrapping to 0
module cmn_rr_arbiter #(
  parameter int p_n = 4,
  localparam int W = $clog2(p_n)
) (
  input  logic [p_n-1:0] req,
  input  logic [W-1:0]   ptr,
  output logic [p_n-1:0] gnt
);
  // Walk from farthest to nearest so the request closest to ptr wins last
  always_comb begin
    gnt = '0;
    for (int k = p_n - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % p_n]) gnt = p_n'(1) << ((int'(ptr) + k) % p_n);
  end
endmodule

// File: rtl/cmn_stream_mux.sv
// cmn_stream_mux: N-to-1 valid/ready stream mux with a single registered output entry
// Defining CMN_STREAM_MUX_LOCK_EN adds in_last and holds the grant for a whole packet
module cmn_stream_mux
  import cmn_pkg::*;
#(
  parameter int p_nbits   = 32,
  parameter int p_ninputs = 4,
  parameter int p_mode    = CMN_MUX_MODE_RR,
  localparam int W = $clog2(p_ninputs)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_ninputs-1:0]         in_val,
  output logic [p_ninputs-1:0]         in_rdy,
  input  logic [p_ninputs*p_nbits-1:0] in_msg,
`ifdef CMN_STREAM_MUX_LOCK_EN
  input  logic [p_ninputs-1:0]         in_last,
`endif
  input  logic [W-1:0]                 sel,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [p_nbits-1:0]           out_msg,
  output logic [W-1:0]                 out_src
);
  logic [W-1:0] ptr_q, ptr_d, src_q, src_d, lidx_q, lidx_d, gidx;
  logic lock_q, lock_d, val_q, val_d, accept, xfer, last;
  logic [p_nbits-1:0] msg_q, msg_d;
  logic [p_ninputs-1:0] rr_gnt, sel_gnt, lock_gnt, gnt;

  cmn_rr_arbiter #(.p_n(p_ninputs)) u_arb (.req(in_val), .ptr(ptr_q), .gnt(rr_gnt));

`ifdef CMN_STREAM_MUX_LOCK_EN
  assign last = in_last[gidx];
`else
  assign last = 1'b1;
`endif

  // A held packet lock overrides both arbitration modes
  always_comb begin
    sel_gnt  = (int'(sel) < p_ninputs && in_val[sel]) ? p_ninputs'(1) << sel : '0;
    lock_gnt = in_val[lidx_q] ? p_ninputs'(1) << lidx_q : '0;
    gnt      = lock_q ? lock_gnt : (p_mode == CMN_MUX_MODE_SEL) ? sel_gnt : rr_gnt;
    accept   = !val_q || out_rdy;
    in_rdy   = (reset || !accept) ? '0 : gnt;
    xfer     = |in_rdy;
    gidx     = '0;
    for (int i = 0; i < p_ninputs; i++) if (gnt[i]) gidx = W'(i);
  end

  always_comb begin
    ptr_d  = (xfer && last) ? ((gidx == W'(p_ninputs - 1)) ? '0 : gidx + W'(1)) : ptr_q;
    lock_d = xfer ? !last : lock_q;
    lidx_d = xfer ? gidx : lidx_q;
    val_d  = xfer || (val_q && !out_rdy);
    msg_d  = xfer ? in_msg[int'(gidx) * p_nbits +: p_nbits] : msg_q;
    src_d  = xfer ? gidx : src_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
      val_q  <= 1'b0;
      msg_q  <= '0;
      src_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
      val_q  <= val_d;
      msg_q  <= msg_d;
      src_q  <= src_d;
    end
  end

  assign out_val = val_q;
  assign out_msg = msg_q;
  assign out_src = src_q;
endmodule
